// File: rtl/operand_triplet_gen_pkg.sv
// Shared types and default sizes for the operand triplet generator.
package operand_triplet_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int DEF_WIDTH   = 8;
   localparam int DEF_COUNT_W = 8;

endpackage

// File: rtl/operand_triplet_gen_lane.sv
// One operand lane: a value register that loads a seed and then advances by a latched step.
module operand_lane #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   input  logic [WIDTH-1:0] step,
   input  logic             adv,
   output logic [WIDTH-1:0] value
);

   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] step_q;

   // load wins over adv; the sum wraps modulo 2^WIDTH
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q <= '0;
         step_q  <= '0;
      end else if (load) begin
         value_q <= seed;
         step_q  <= step;
      end else if (adv) begin
         value_q <= value_q + step_q;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/operand_triplet_gen.sv
// Emits a programmed number of (a,b,c) triplets over valid/ready; optional running XOR
// checksum output chk is enabled by defining OPERAND_TRIPLET_GEN_CHECKSUM_EN.
module operand_triplet_gen
   import operand_triplet_gen_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int COUNT_W = DEF_COUNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [COUNT_W-1:0] len,
   input  logic [WIDTH-1:0]   seed_a,
   input  logic [WIDTH-1:0]   seed_b,
   input  logic [WIDTH-1:0]   seed_c,
   input  logic [WIDTH-1:0]   step_a,
   input  logic [WIDTH-1:0]   step_b,
   input  logic [WIDTH-1:0]   step_c,
   input  logic               ready,
   output logic               valid,
   output logic [WIDTH-1:0]   a,
   output logic [WIDTH-1:0]   b,
   output logic [WIDTH-1:0]   c,
   output logic [COUNT_W-1:0] remaining,
   output logic               busy,
   output logic               done,
`ifdef OPERAND_TRIPLET_GEN_CHECKSUM_EN
   output logic [WIDTH-1:0]   chk,
`endif
   output state_e             dbg_state
);

   // Handshake: a triplet transfers on any rising edge where valid && ready; valid stays
   // high with a/b/c/remaining frozen until that happens, and ready never feeds an output
   // combinationally.

   state_e             state_q;
   logic               valid_q;
   logic               busy_q;
   logic               done_q;
   logic [COUNT_W-1:0] remaining_q;

   logic start_ok;
   logic load;
   logic adv;

   assign start_ok = (state_q == ST_IDLE) && start;
   assign load     = start_ok && (len != '0);
   assign adv      = valid_q && ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         remaining_q <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  if (len != '0) begin
                     state_q     <= ST_RUN;
                     valid_q     <= 1'b1;
                     busy_q      <= 1'b1;
                     remaining_q <= len;
                  end else begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (ready) begin
                  remaining_q <= remaining_q - COUNT_W'(1);
                  if (remaining_q == COUNT_W'(1)) begin
                     state_q <= ST_DONE;
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   operand_lane #(.WIDTH(WIDTH)) u_lane_a (
      .clk(clk), .rst(rst), .load(load), .seed(seed_a), .step(step_a), .adv(adv), .value(a)
   );
   operand_lane #(.WIDTH(WIDTH)) u_lane_b (
      .clk(clk), .rst(rst), .load(load), .seed(seed_b), .step(step_b), .adv(adv), .value(b)
   );
   operand_lane #(.WIDTH(WIDTH)) u_lane_c (
      .clk(clk), .rst(rst), .load(load), .seed(seed_c), .step(step_c), .adv(adv), .value(c)
   );

`ifdef OPERAND_TRIPLET_GEN_CHECKSUM_EN
   logic [WIDTH-1:0] chk_q;

   // Folds in the triplet being accepted, i.e. the lane values before they advance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chk_q <= '0;
      end else if (start_ok) begin
         chk_q <= '0;
      end else if (adv) begin
         chk_q <= chk_q ^ a ^ b ^ c;
      end
   end

   assign chk = chk_q;
`endif

   assign valid     = valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign remaining = remaining_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_operand_triplet_gen.sv
// Directed bench for operand_triplet_gen; also checks chk when OPERAND_TRIPLET_GEN_CHECKSUM_EN is defined.
module tb_operand_triplet_gen;
  import operand_triplet_gen_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] len;
  logic [7:0] seed_a, seed_b, seed_c;
  logic [7:0] step_a, step_b, step_c;
  logic       ready;
  logic       valid, busy, done;
  logic [7:0] a, b, c, remaining;
  state_e     dbg_state;
`ifdef OPERAND_TRIPLET_GEN_CHECKSUM_EN
  logic [7:0] chk;
`endif

  int tests = 0;
  int fails = 0;

  operand_triplet_gen dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .seed_a(seed_a), .seed_b(seed_b), .seed_c(seed_c),
    .step_a(step_a), .step_b(step_b), .step_c(step_c),
    .ready(ready), .valid(valid), .a(a), .b(b), .c(c),
    .remaining(remaining), .busy(busy), .done(done),
`ifdef OPERAND_TRIPLET_GEN_CHECKSUM_EN
    .chk(chk),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic program_run(input logic [7:0] l,
                             input logic [7:0] sa, input logic [7:0] sb, input logic [7:0] sc,
                             input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] tc);
    len = l;
    seed_a = sa; seed_b = sb; seed_c = sc;
    step_a = ta; step_b = tb; step_c = tc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_trip(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                            input logic [7:0] ec, input logic [7:0] erem);
    check({tag, ".valid"}, 32'(valid), 32'd1);
    check({tag, ".a"}, 32'(a), 32'(ea));
    check({tag, ".b"}, 32'(b), 32'(eb));
    check({tag, ".c"}, 32'(c), 32'(ec));
    check({tag, ".rem"}, 32'(remaining), 32'(erem));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"}, 32'(valid), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".a"}, 32'(a), 32'd0);
    check({tag, ".b"}, 32'(b), 32'd0);
    check({tag, ".c"}, 32'(c), 32'd0);
    check({tag, ".rem"}, 32'(remaining), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b0; len = '0;
    seed_a = '0; seed_b = '0; seed_c = '0;
    step_a = '0; step_b = '0; step_c = '0;
    tick();
    tick();
    check_zero("reset");
    check("reset.state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    tick();

    // basic sequence
    ready = 1'b1;
    program_run(8'd3, 8'd5, 8'd6, 8'd7, 8'd1, 8'd2, 8'd3);
    check_trip("basic0", 8'd5, 8'd6, 8'd7, 8'd3);
    check("basic0.busy", 32'(busy), 32'd1);
    tick();
    check_trip("basic1", 8'd6, 8'd8, 8'd10, 8'd2);
    tick();
    check_trip("basic2", 8'd7, 8'd10, 8'd13, 8'd1);
    tick();
    check("basic.done", 32'(done), 32'd1);
    check("basic.done_valid", 32'(valid), 32'd0);
    check("basic.done_busy", 32'(busy), 32'd0);
    check("basic.hold_a", 32'(a), 32'd8);
`ifdef OPERAND_TRIPLET_GEN_CHECKSUM_EN
    check("basic.chk", 32'(chk), 32'd0);
`endif
    // start in the done cycle must be ignored
    len = 8'd2; seed_a = 8'd99; start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_done.done", 32'(done), 32'd0);
    check("ign_done.valid", 32'(valid), 32'd0);
    check("ign_done.state", 32'(dbg_state), 32'(ST_IDLE));
    check("ign_done.a", 32'(a), 32'd8);

    // back-pressure: four stalled cycles
    ready = 1'b0;
    program_run(8'd3, 8'd5, 8'd6, 8'd7, 8'd1, 8'd2, 8'd3);
    check_trip("stall0", 8'd5, 8'd6, 8'd7, 8'd3);
    for (int i = 1; i < 4; i++) begin
      tick();
      check_trip($sformatf("stall%0d", i), 8'd5, 8'd6, 8'd7, 8'd3);
    end
    ready = 1'b1;
    tick();
    check_trip("bp1", 8'd6, 8'd8, 8'd10, 8'd2);
    tick();
    check_trip("bp2", 8'd7, 8'd10, 8'd13, 8'd1);
    tick();
    check("bp.done", 32'(done), 32'd1);
    tick();
    check("bp.done_gone", 32'(done), 32'd0);

    // wrap-around on lane a
    program_run(8'd3, 8'd250, 8'd0, 8'd0, 8'd4, 8'd0, 8'd0);
    check("wrap0.a", 32'(a), 32'd250);
    tick();
    check("wrap1.a", 32'(a), 32'd254);
    tick();
    check("wrap2.a", 32'(a), 32'd2);
    check("wrap2.rem", 32'(remaining), 32'd1);
    tick();
    check("wrap.done", 32'(done), 32'd1);
    tick();

    // zero length
    program_run(8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
    check("zero.done", 32'(done), 32'd1);
    check("zero.valid", 32'(valid), 32'd0);
    check("zero.state", 32'(dbg_state), 32'(ST_DONE));
    tick();
    check("zero.done_gone", 32'(done), 32'd0);
    check("zero.valid2", 32'(valid), 32'd0);

    // ignored start during RUN, then asynchronous reset after two transfers
    program_run(8'd5, 8'd10, 8'd20, 8'd30, 8'd1, 8'd1, 8'd1);
    check_trip("run0", 8'd10, 8'd20, 8'd30, 8'd5);
    seed_a = 8'd100; seed_b = 8'd100; seed_c = 8'd100; len = 8'd9; start = 1'b1;
    tick();
    start = 1'b0;
    check_trip("ign_run", 8'd11, 8'd21, 8'd31, 8'd4);
    tick();
    check_trip("run2", 8'd12, 8'd22, 8'd32, 8'd3);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    tick();
    check_zero("rst_hold");
    rst = 1'b0;
    tick();
    check("post_rst.done", 32'(done), 32'd0);
    program_run(8'd2, 8'd1, 8'd2, 8'd3, 8'd1, 8'd1, 8'd1);
    check_trip("restart0", 8'd1, 8'd2, 8'd3, 8'd2);
    tick();
    check_trip("restart1", 8'd2, 8'd3, 8'd4, 8'd1);
    tick();
    check("restart.done", 32'(done), 32'd1);
    tick();

`ifdef OPERAND_TRIPLET_GEN_CHECKSUM_EN
    program_run(8'd3, 8'd5, 8'd6, 8'd7, 8'd1, 8'd2, 8'd3);
    check("chk.cleared", 32'(chk), 32'd0);
    tick();
    check("chk.after1", 32'(chk), 32'd4);
    tick();
    tick();
    check("chk.basic", 32'(chk), 32'd0);
    tick();
    program_run(8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    check("chk.single", 32'(chk), 32'd1);
    tick();
    check("chk.hold", 32'(chk), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
